// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel divider, h/v counters, registered syncs and tick strobes.
// Defining VGA_SYNC_FRAME_CNT_EN builds a free-running 6-bit frame counter; otherwise frame_cnt is 0.
module vga_sync_gen #(
  parameter int DIV = 4,
  parameter int HD  = 640,
  parameter int HF  = 16,
  parameter int HR  = 96,
  parameter int HB  = 48,
  parameter int VD  = 480,
  parameter int VF  = 10,
  parameter int VR  = 2,
  parameter int VB  = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [5:0] frame_cnt
);

  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_DISP   = 10'(HD);
  localparam logic [9:0] V_DISP   = 10'(VD);
  // Retrace windows as inclusive bounds so a window ending at 1023 still fits 10 bits.
  localparam logic [9:0] H_RS     = 10'(HD + HF);
  localparam logic [9:0] H_RE     = 10'(HD + HF + HR - 1);
  localparam logic [9:0] V_RS     = 10'(VD + VF);
  localparam logic [9:0] V_RE     = 10'(VD + VF + VR - 1);

  logic [3:0] div_cnt;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;

  assign pixel_tick = (div_cnt == DIV_LAST);
  assign line_tick  = pixel_tick && (h_cnt == H_LAST);
  assign frame_tick = line_tick && (v_cnt == V_LAST);

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pixel_tick) h_nxt = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
    if (line_tick)  v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
  end

  // Syncs decode the next-state counters so they move on the same edge as pix_x/pix_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= 4'd0;
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      div_cnt <= pixel_tick ? 4'd0 : div_cnt + 4'd1;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      hsync   <= !((h_nxt >= H_RS) && (h_nxt <= H_RE));
      vsync   <= !((v_nxt >= V_RS) && (v_nxt <= V_RE));
    end
  end

  assign pix_x    = h_cnt;
  assign pix_y    = v_cnt;
  assign video_on = (h_cnt < H_DISP) && (v_cnt < V_DISP);

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [5:0] frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           frame_q <= 6'd0;
    else if (frame_tick) frame_q <= frame_q + 6'd1;
  end

  assign frame_cnt = frame_q;
`else
  assign frame_cnt = 6'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing and small-timing instances, hand-written vectors
// plus a per-cycle arithmetic reference model under randomized reset points.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pt;
    logic       lt;
    logic       ft;
    logic       hs;
    logic       vs;
    logic       von;
    logic [5:0] fc;
  } obs_t;

  typedef struct {
    int   sel;
    int   k;
    obs_t exp;
  } vec_t;

`ifdef VGA_SYNC_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pt0, lt0, ft0, hs0, vs0, von0;
  logic [9:0] px0, py0;
  logic [5:0] fc0;
  logic       pt1, lt1, ft1, hs1, vs1, von1;
  logic [9:0] px1, py1;
  logic [5:0] fc1;

  vga_sync_gen d0 (
    .clk(clk), .reset(rst), .pixel_tick(pt0), .line_tick(lt0), .frame_tick(ft0),
    .hsync(hs0), .vsync(vs0), .video_on(von0), .pix_x(px0), .pix_y(py0), .frame_cnt(fc0)
  );

  vga_sync_gen #(
    .DIV(2), .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1)
  ) d1 (
    .clk(clk), .reset(rst), .pixel_tick(pt1), .line_tick(lt1), .frame_tick(ft1),
    .hsync(hs1), .vsync(vs1), .video_on(von1), .pix_x(px1), .pix_y(py1), .frame_cnt(fc1)
  );

  obs_t a0, a1;
  assign a0 = {px0, py0, pt0, lt0, ft0, hs0, vs0, von0, fc0};
  assign a1 = {px1, py1, pt1, lt1, ft1, hs1, vs1, von1, fc1};

  int tests = 0;
  int fails = 0;
  int cyc;
  bit go = 1'b0;

  // Clocks elapsed since reset release.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Reference: position is plain division of elapsed clocks by pixel/line/frame sizes.
  function automatic obs_t model(int div, int hd, int hf, int hr, int hb,
                                 int vd, int vf, int vr, int vb, int k);
    obs_t o;
    int ht, vt, p, h, ln, v, fr;
    ht = hd + hf + hr + hb;
    vt = vd + vf + vr + vb;
    p  = k / div;
    h  = p % ht;
    ln = p / ht;
    v  = ln % vt;
    fr = ln / vt;
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.pt  = ((k % div) == div - 1);
    o.lt  = o.pt && (h == ht - 1);
    o.ft  = o.lt && (v == vt - 1);
    o.hs  = !((h >= hd + hf) && (h < hd + hf + hr));
    o.vs  = !((v >= vd + vf) && (v < vd + vf + vr));
    o.von = (h < hd) && (v < vd);
    o.fc  = FC_EN ? 6'(fr % 64) : 6'd0;
    return o;
  endfunction

  function automatic obs_t m0(int k);
    return model(4, 640, 16, 96, 48, 480, 10, 2, 33, k);
  endfunction

  function automatic obs_t m1(int k);
    return model(2, 8, 2, 2, 2, 4, 1, 1, 1, k);
  endfunction

  task automatic check(string name, int k, obs_t act, obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s k=%0d: got x=%0d y=%0d pt/lt/ft=%b%b%b hs/vs=%b%b von=%b fc=%0d, want x=%0d y=%0d pt/lt/ft=%b%b%b hs/vs=%b%b von=%b fc=%0d",
               name, k, act.x, act.y, act.pt, act.lt, act.ft, act.hs, act.vs, act.von, act.fc,
               exp.x, exp.y, exp.pt, exp.lt, exp.ft, exp.hs, exp.vs, exp.von, exp.fc);
    end
  endtask

  always @(negedge clk) begin
    if (go && !rst) begin
      check("model_d0", cyc, a0, m0(cyc));
      check("model_d1", cyc, a1, m1(cyc));
    end
  end

  function automatic vec_t vec(int s, int k, int x, int y, bit pt, bit lt, bit ft,
                               bit hs, bit vs, bit von, int fc);
    vec_t r;
    r.sel = s;
    r.k   = k;
    r.exp = {10'(x), 10'(y), pt, lt, ft, hs, vs, von, 6'(fc)};
    return r;
  endfunction

  vec_t tbl[$];

  task automatic release_at_negedge();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int fc63, fc1;
    fc63 = FC_EN ? 63 : 0;
    fc1  = FC_EN ? 1 : 0;
    //               sel k      x    y  pt lt ft hs vs von fc
    tbl.push_back(vec(0, 0,     0,   0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(1, 0,     0,   0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(1, 1,     0,   0, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(1, 2,     1,   0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(0, 3,     0,   0, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(0, 4,     1,   0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(1, 20,    10,  0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(vec(1, 23,    11,  0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(vec(1, 24,    12,  0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vec(1, 27,    13,  0, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(vec(1, 28,    0,   1, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(1, 140,   0,   5, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(vec(1, 167,   13,  5, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(vec(1, 168,   0,   6, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vec(1, 195,   13,  6, 1, 1, 1, 1, 1, 0, 0));
    tbl.push_back(vec(1, 196,   0,   0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(0, 2559,  639, 0, 1, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(0, 2560,  640, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vec(0, 2623,  655, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vec(0, 2624,  656, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(vec(0, 3007,  751, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(vec(0, 3008,  752, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(vec(0, 3199,  799, 0, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(vec(0, 3200,  0,   1, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(1, 12543, 13,  6, 1, 1, 1, 1, 1, 0, fc63));
    tbl.push_back(vec(1, 12544, 0,   0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(vec(1, 12740, 0,   0, 0, 0, 0, 1, 1, 1, fc1));

    // Power-on reset values while reset is held.
    repeat (3) @(negedge clk);
    check("reset_d0", 0, a0, m0(0));
    check("reset_d1", 0, a1, m1(0));
    go = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      while (cyc < tbl[i].k) @(negedge clk);
      check(tbl[i].sel ? "vec_d1" : "vec_d0", tbl[i].k, tbl[i].sel ? a1 : a0, tbl[i].exp);
    end

    // Mid-line reset at h=300 on the default instance: values must clear before the next edge.
    rst = 1'b1;
    release_at_negedge();
    while (cyc < 1200) @(negedge clk);
    check("pre_reset_h300", cyc, a0, vec(0, 0, 300, 0, 0, 0, 0, 1, 1, 1, 0).exp);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_d0", 0, a0, m0(0));
    check("async_reset_d1", 0, a1, m1(0));
    release_at_negedge();
    repeat (3) @(negedge clk);
    check("first_tick_after_reset", cyc, a0, vec(0, 3, 0, 0, 1, 0, 0, 1, 1, 1, 0).exp);

    // Randomized async reset points, then free run checked every cycle by the model.
    for (int it = 0; it < 8; it++) begin
      @(posedge clk);
      #($urandom_range(1, 3)) rst = 1'b1;
      #1;
      check("rand_async_d0", 0, a0, m0(0));
      check("rand_async_d1", 0, a1, m1(0));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #($urandom_range(1, 4)) rst = 1'b0;
      repeat ($urandom_range(50, 3000)) @(negedge clk);
    end

    go = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock. Drives `video_on`, `pix_x`, `pix_y`, `hsync` and `vsync` into the pixel renderer (the clock/alarm text and digit display path) and onto the VGA connector. It also emits pixel, line and frame strobes for downstream logic such as frame-synchronous blinking while the time is being set.

## Interface
- `DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal range 2..16.
- `HD`, 640: horizontal display pixels.
- `HF`, 16: horizontal front porch pixels.
- `HR`, 96: horizontal retrace pixels.
- `HB`, 48: horizontal back porch pixels.
- `VD`, 480: vertical display lines.
- `VF`, 10: vertical front porch lines.
- `VR`, 2: vertical retrace lines.
- `VB`, 33: vertical back porch lines.
- `clk  in  1  system clock, 100 MHz; single clock domain`
- `reset  in  1  asynchronous, active-high; clears all state`
- `pixel_tick  out  1  one-clk pulse; marks the clock on which the pixel counter advances`
- `line_tick  out  1  one-clk pulse, coincident with the pixel_tick that wraps h_cnt`
- `frame_tick  out  1  one-clk pulse, coincident with the line_tick that wraps v_cnt`
- `hsync  out  1  horizontal sync, active-low, registered`
- `vsync  out  1  vertical sync, active-low, registered`
- `video_on  out  1  high while pix_x < HD and pix_y < VD`
- `pix_x  out  10  current horizontal count, 0..HD+HF+HR+HB-1`
- `pix_y  out  10  current vertical count, 0..VD+VF+VR+VB-1`
- `frame_cnt  out  6  free-running frame counter (see Configuration)`

## Operation
- Definitions: HT = HD+HF+HR+HB = 800 and VT = VD+VF+VR+VB = 525 at defaults.
- Divider:
  - `div_cnt` counts 0..DIV-1 and wraps to 0.
  - `pixel_tick` = (div_cnt == DIV-1); it is combinational from the register.
- Horizontal counter:
  - `h_cnt` is updated only on clocks where `pixel_tick` is high.
  - At HT-1 it wraps to 0; otherwise it increments by 1.
  - `line_tick` = `pixel_tick` && (h_cnt == HT-1).
- Vertical counter:
  - `v_cnt` is updated only on clocks where `line_tick` is high.
  - At VT-1 it wraps to 0; otherwise it increments by 1.
  - `frame_tick` = `line_tick` && (v_cnt == VT-1).
- Scan order per line: display 0..HD-1, front porch, retrace HD+HF..HD+HF+HR-1 (656..751), back porch. The vertical scan uses the same order, with retrace on lines 490..491.
- Sync generation:
  - `hsync` and `vsync` are flops loaded from the decode of the next-state counter values.
  - They therefore change on the same edge as `h_cnt`/`v_cnt`.
  - They are asserted (low) exactly while the corresponding counter is inside its retrace window.
- Pixel outputs:
  - `pix_x` = `h_cnt` and `pix_y` = `v_cnt`.
  - `video_on` is decoded combinationally from the registered counters.
- Width rule: `h_cnt` and `v_cnt` are 10 bits. The parameter sets must satisfy HT ≤ 1024 and VT ≤ 1024.

## Timing
- Reset values:
  - `div_cnt`, `h_cnt`, `v_cnt` and `frame_cnt` are all 0.
  - `hsync` and `vsync` are 1 (deasserted).
  - `pixel_tick`, `line_tick` and `frame_tick` are 0.
  - `video_on` is 1, because (0,0) is inside the display area.
  - `pix_x` and `pix_y` are 0.
- After reset release, the first `pixel_tick` occurs on the 4th clock (div_cnt = 3). `h_cnt` becomes 1 on the following edge.
- Each pixel lasts DIV = 4 clocks. Each line lasts 3200 clocks. Each frame lasts 1,680,000 clocks.
- Outputs change once per pixel, on the edge ending a `pixel_tick` clock. They are stable for the other DIV-1 clocks.
- Simultaneous wrap:
  - When `h_cnt` = HT-1 and `v_cnt` = VT-1 on a `pixel_tick`, both counters go to 0 on the same edge.
  - On that edge `vsync` and `hsync` update together. `pixel_tick`, `line_tick` and `frame_tick` are all high on that clock.
- Reset mid-frame: reset forces the reset values immediately (asynchronously). Scanning restarts at (0,0) with a full DIV count.

## Configuration
- Macro: `VGA_SYNC_FRAME_CNT_EN`.
- Defined: `frame_cnt` is a 6-bit register that increments on each `frame_tick` and wraps 63→0. Reset value is 0.
- Undefined: no frame counter register is built, and `frame_cnt` is tied to 6'd0. The port list is identical in both builds.

## Test plan
- **Reset values:** assert reset mid-line at h=300, v=100 → all outputs take their reset values asynchronously, before the next clk edge. After release, the first `pixel_tick` occurs at clock 4.
- **Horizontal timing:** run one line.
  - `hsync` falls on the edge where `pix_x` becomes 656 and rises where it becomes 752; low time is 384 clks.
  - `line_tick` pulses once per 3200 clks.
  - `video_on` falls when `pix_x` becomes 640.
- **Vertical timing:**
  - `vsync` falls when `pix_y` becomes 490 and rises when it becomes 492; low time is 6400 clks.
  - `video_on` stays low for `pix_y` 480..524.
- **Frame wrap:** at (799,524), on the `pixel_tick` clock → all three ticks are high on one clock. The next edge gives `pix_x` = `pix_y` = 0, `video_on` = 1 and `frame_tick` period = 1,680,000 clks.
- **Frame counter:**
  - With `VGA_SYNC_FRAME_CNT_EN`, 65 frames → `frame_cnt` reads 1, having wrapped at 64.
  - Without the macro → `frame_cnt` stays 0 throughout.
- **Parameter override:** DIV=2, HD=8, HF=2, HR=2, HB=2, VD=4, VF=1, VR=1, VB=1 → line = 28 clks and frame = 196 clks. `hsync` is low for `pix_x` 10..11 and `vsync` is low for `pix_y` 5.
